vga_sync_decoder: RTL

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from raw VGA hsync/vsync and tracks whether the
// incoming line timing matches the expected H_TOTAL / HS_WIDTH profile.
module vga_sync_decoder #(
    parameter int H_TOTAL    = 800,
    parameter int HS_WIDTH   = 96,
    parameter int LOCK_LINES = 4
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic       vga_hs,
    input  logic       vga_vs,
    output logic [9:0] h_pos,
    output logic [9:0] v_pos,
    output logic [9:0] line_len,
    output logic [9:0] hs_len,
    output logic [9:0] frame_lines,
    output logic       new_line,
    output logic       new_frame,
    output logic       locked,
    output logic       timing_err
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] MAX10 = 10'd1023;

    state_t      state;
    state_t      state_next;
    logic [2:0]  good_cnt;
    logic [2:0]  good_next;
    logic        err_next;
    logic        hs_s1;
    logic        hs_s2;
    logic        vs_s1;
    logic        vs_s2;
    logic [9:0]  pulse_cnt;
    logic        hs_lead;
    logic        hs_trail;
    logic        vs_lead;
    logic [10:0] meas_len;
    logic        good_line;

    assign hs_lead  = hs_s2 & ~hs_s1;
    assign hs_trail = ~hs_s2 & hs_s1;
    assign vs_lead  = vs_s2 & ~vs_s1;
    // Eleven bits so a saturated h_pos (1023 + 1) can never alias a valid length.
    assign meas_len  = {1'b0, h_pos} + 11'd1;
    assign good_line = (meas_len == 11'(H_TOTAL)) && (hs_len == 10'(HS_WIDTH));

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_next   = 1'b0;
        case (state)
            SEARCH: begin
                if (hs_lead) begin
                    state_next = VERIFY;
                    good_next  = 3'd0;
                end
            end
            VERIFY: begin
                if (h_pos == MAX10) begin
                    state_next = SEARCH;
                    good_next  = 3'd0;
                    err_next   = 1'b1;
                end else if (hs_lead) begin
                    if (good_line) begin
                        good_next = (good_cnt == 3'd7) ? good_cnt : good_cnt + 3'd1;
                        if (int'(good_next) >= LOCK_LINES) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        good_next = 3'd0;
                    end
                end
            end
            LOCKED: begin
                if (h_pos == MAX10) begin
                    state_next = SEARCH;
                    good_next  = 3'd0;
                    err_next   = 1'b1;
                end else if (hs_lead && !good_line) begin
                    state_next = VERIFY;
                    good_next  = 3'd0;
                    err_next   = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
                good_next  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            good_cnt   <= 3'd0;
            timing_err <= 1'b0;
            locked     <= 1'b0;
            new_line   <= 1'b0;
            new_frame  <= 1'b0;
            hs_s1      <= 1'b1;
            hs_s2      <= 1'b1;
            vs_s1      <= 1'b1;
            vs_s2      <= 1'b1;
        end else begin
            state      <= state_next;
            good_cnt   <= good_next;
            timing_err <= err_next;
            locked     <= (state_next == LOCKED);
            new_line   <= hs_lead;
            new_frame  <= vs_lead;
            hs_s1      <= vga_hs;
            hs_s2      <= hs_s1;
            vs_s1      <= vga_vs;
            vs_s2      <= vs_s1;
        end
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            h_pos       <= 10'd0;
            v_pos       <= 10'd0;
            line_len    <= 10'd0;
            hs_len      <= 10'd0;
            frame_lines <= 10'd0;
            pulse_cnt   <= 10'd0;
        end else begin
            if (hs_lead) begin
                line_len <= meas_len[9:0];
                h_pos    <= 10'd0;
            end else if (h_pos != MAX10) begin
                h_pos <= h_pos + 10'd1;
            end

            // A vsync edge restarts the frame even if an hsync edge lands on the same clock.
            if (vs_lead) begin
                frame_lines <= v_pos + 10'd1;
                v_pos       <= 10'd0;
            end else if (hs_lead && v_pos != MAX10) begin
                v_pos <= v_pos + 10'd1;
            end

            if (hs_trail) begin
                hs_len    <= pulse_cnt;
                pulse_cnt <= 10'd0;
            end else if (!hs_s1) begin
                if (hs_lead) begin
                    pulse_cnt <= 10'd1;
                end else if (pulse_cnt != MAX10) begin
                    pulse_cnt <= pulse_cnt + 10'd1;
                end
            end
        end
    end

endmodule
